// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of the 8-bit UART transmitter. Bytes arrive
// over a valid/ready port and are launched one at a time with a single-cycle
// tx_start pulse. The next byte waits until the current frame has finished.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_wr_valid/i_wr_data/o_wr_ready   producer byte interface
//   i_flush           synchronous clear of the queued bytes
//   i_clr_ovf         synchronous clear of o_overflow
//   i_tx_ready        transmitter idle
//   o_tx_start        one-cycle launch pulse
//   o_tx_data         byte in flight, held until the FSM is back in IDLE
//   o_count           queued bytes (in-flight byte excluded)
//   o_empty/o_full    queue status
//   o_overflow        sticky: write attempted while full
//   o_tx_err          one-cycle pulse when the transmitter never acknowledged
module uart_tx_feeder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_valid,
    input  logic [7:0]               i_wr_data,
    output logic                     o_wr_ready,
    input  logic                     i_flush,
    input  logic                     i_clr_ovf,
    input  logic                     i_tx_ready,
    output logic                     o_tx_start,
    output logic [7:0]               o_tx_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic                     o_tx_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_empty;
    logic            r_full;
    logic            r_wr_ready;
    logic            r_overflow;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic            r_tx_err;
    logic [TW-1:0]   r_tmr;

    logic            w_push;
    logic            w_pop;
    logic            w_tmr_load;
    logic            w_tmr_dec;
    logic            w_err;

    // Push uses the registered full flag, so a same-edge pop never frees room.
    assign w_push = i_wr_valid && !r_full && !i_flush;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && i_tx_ready && !i_flush) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_tmr == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (i_tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM control outputs; they feed the registered outputs below
    always_comb begin
        w_pop      = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = !r_empty && i_tx_ready && !i_flush;
            end
            S_START: begin
                w_tmr_load = 1'b1;
            end
            S_WAIT_BUSY: begin
                if (i_tx_ready) begin
                    if (r_tmr == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Queue occupancy; flush overrides any push or pop
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers, status flags and transmitter-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_wr_ready <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_err   <= 1'b0;
            r_tmr      <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_wr_ready <= (w_count_nxt != CW'(DEPTH));

            if (i_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + AW'(1);
                end
                if (w_pop) begin
                    r_rp <= r_rp + AW'(1);
                end
            end

            // Set wins over a same-edge clear
            if (i_wr_valid && r_full && !i_flush) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end

            r_tx_start <= w_pop;
            r_tx_err   <= w_err;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rp];
            end

            if (w_tmr_load) begin
                r_tmr <= TW'(ACK_TIMEOUT - 1);
            end else if (w_tmr_dec) begin
                r_tmr <= r_tmr - TW'(1);
            end
        end
    end

    // Storage array; contents are not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    assign o_wr_ready = r_wr_ready;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_count    = r_count;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;
    assign o_tx_err   = r_tx_err;

endmodule
